// File: rtl/elastic_fifo.sv
// elastic_fifo: first-word-fall-through ready/valid FIFO with a registered occupancy count
module elastic_fifo #(
  parameter int width_p = 8,
  parameter int depth_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [width_p-1:0]           data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic [$clog2(depth_p+1)-1:0] count_o
);
  localparam int ptr_width_lp = $clog2(depth_p) + 1;
  localparam int idx_width_lp = $clog2(depth_p);
  localparam int count_width_lp = $clog2(depth_p + 1);
  logic [width_p-1:0] mem [depth_p];
  logic [ptr_width_lp-1:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop;
  // the wrap bit distinguishes full from empty when the indices coincide
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[idx_width_lp-1:0] == rd_ptr[idx_width_lp-1:0]) &&
                (wr_ptr[ptr_width_lp-1] != rd_ptr[ptr_width_lp-1]);
  assign ready_o = ~full && reset_ni;
  assign valid_o = ~empty;
  assign data_o = mem[rd_ptr[idx_width_lp-1:0]];
  assign push = valid_i && ready_o;
  assign pop = valid_o && ready_i;
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[idx_width_lp-1:0]] <= data_i;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_width_lp'(1);
      if (pop) rd_ptr <= rd_ptr + ptr_width_lp'(1);
      count_o <= (push && !pop) ? count_o + count_width_lp'(1) :
                 (pop && !push) ? count_o - count_width_lp'(1) : count_o;
    end
  end
endmodule
